// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor: start request,
// parallel operands, busy/done status and the parallel result with flags.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             overflow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow, overflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow, overflow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one bit per clock LSB first, with a
// registered borrow. One result per WIDTH+1 cycles when start is held.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sb_q, res_q, diff_q;
  logic [CNT_W-1:0] cnt_q;
  logic             bf_q, a_msb_q, b_msb_q, borrow_q, ovf_q;
  logic             accept, last_bit;
  logic             a0, b0, d, bf_d;
  logic [WIDTH-1:0] res_d;

  function automatic logic sub_bit(input logic x, input logic y, input logic bi);
    return x ^ y ^ bi;
  endfunction

  function automatic logic sub_borrow(input logic x, input logic y, input logic bi);
    return (~x & y) | (~(x ^ y) & bi);
  endfunction

  assign a0       = sa_q[0];
  assign b0       = sb_q[0];
  assign d        = sub_bit(a0, b0, bf_q);
  assign bf_d     = sub_borrow(a0, b0, bf_q);
  assign res_d    = {d, res_q[WIDTH-1:1]};
  assign last_bit = (cnt_q == LAST);

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        bus.busy = 1'b1;
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        // start during the done cycle chains straight into the next operation
        if (bus.start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // datapath: operand load on accept, one bit per edge while running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      bf_q     <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      sa_q    <= bus.a;
      sb_q    <= bus.b;
      bf_q    <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= bus.a[WIDTH-1];
      b_msb_q <= bus.b[WIDTH-1];
    end else if (state_q == RUN) begin
      sa_q  <= {1'b0, sa_q[WIDTH-1:1]};
      sb_q  <= {1'b0, sb_q[WIDTH-1:1]};
      res_q <= res_d;
      bf_q  <= bf_d;
      cnt_q <= cnt_q + CNT_W'(1);
      if (last_bit) begin
        diff_q   <= res_d;
        borrow_q <= bf_d;
        // the bit produced on this edge is the result MSB
        ovf_q    <= (a_msb_q != b_msb_q) && (d != a_msb_q);
      end
    end
  end

  assign bus.diff     = diff_q;
  assign bus.borrow   = borrow_q;
  assign bus.overflow = ovf_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned/two's-complement subtractor. Computes diff = a - b, LSB first, one bit per clock, using a registered borrow.
- Parallel operands are loaded on a start/busy/done handshake. The result is presented in parallel with borrow-out and signed-overflow flags.
- Used in the adder/subtractor library where area matters more than latency. It is the subtracting, sequential counterpart of the combinational half/full adder cells.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2 to 32).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled on a rising edge only when the block is idle or done
- a  input  WIDTH  minuend, sampled on the accepting edge only
- b  input  WIDTH  subtrahend, sampled on the accepting edge only
- busy  output  1  high while an operation is in progress (RUN state)
- done  output  1  one-cycle pulse: result outputs are valid and updated
- diff  output  WIDTH  a - b modulo 2^WIDTH
- borrow  output  1  final borrow-out; 1 exactly when a < b (unsigned)
- overflow  output  1  signed overflow: a[MSB] != b[MSB] and diff[MSB] != a[MSB]

Behaviour:
- Reset:
  - Asynchronous: rst_n low forces state IDLE and clears busy, done, diff, borrow, overflow, all shift registers, the borrow flip-flop and the bit counter to 0 immediately, independent of clk.
  - Reset deassertion must not itself launch an operation.
- State IDLE:
  - busy=0, done=0.
  - If start=1 on an edge: load a into shift register SA and b into SB, clear borrow flip-flop BF, clear counter CNT, latch a[MSB] and b[MSB], go to RUN.
  - The result outputs keep their previous values.
- State RUN (busy=1):
  - Each edge processes bit i = CNT, using a0=SA[0], b0=SB[0].
  - d = a0 ^ b0 ^ BF.
  - BF <= (~a0 & b0) | (~(a0 ^ b0) & BF).
  - d shifts into the internal result register from the MSB end. SA and SB shift right by 1. CNT increments.
  - On the edge processing bit WIDTH-1:
    - diff <= completed result; borrow <= final BF.
    - overflow <= (latched a MSB != latched b MSB) and (result MSB != latched a MSB).
    - done <= 1, busy <= 0, go to DONE.
  - start is ignored in RUN; a and b may change freely.
- State DONE:
  - done=1 for exactly this one cycle.
  - The next edge returns to IDLE with done=0. If start=1 on that edge, the operation is accepted exactly as from IDLE and the state goes directly to RUN (back-to-back throughput: one result per WIDTH+1 cycles).
- Latency:
  - start accepted on edge k; done is high in the cycle following edge k+WIDTH.
  - diff, borrow and overflow change only on that edge and are held until the next completion or reset.
- Width rules:
  - All arithmetic is modulo 2^WIDTH.
  - The counter needs ceil(log2(WIDTH)) bits and must terminate at WIDTH-1 without wrap for all legal WIDTH.
- Reset mid-operation: the operation is aborted, no done pulse is produced, and outputs read 0.
- No X on any output after reset, regardless of input values.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, start one cycle -> busy high 8 cycles, done exactly one cycle after edge k+8, diff=0x02, borrow=0, overflow=0.
- a=0x03, b=0x05 -> diff=0xFE, borrow=1, overflow=0; then a=0x80, b=0x01 -> diff=0x7F, borrow=0, overflow=1; a=0x7F, b=0xFF -> diff=0x80, borrow=1, overflow=1.
- Start op a=0x10, b=0x01; pulse start with a=0xAA, b=0x55 while busy -> ignored, result diff=0x0F; hold start high through DONE -> second op accepted back-to-back, busy reasserts the cycle after done.
- Start a=0x40, b=0x01, drop rst_n mid-cycle after 4 edges -> all outputs 0 immediately without a clock edge, no done pulse; release reset, start a=0x09, b=0x09 -> diff=0x00, borrow=0, overflow=0.
- WIDTH=4, exhaustive 256 operand pairs, back-to-back -> diff, borrow and overflow match the reference model (a-b)&0xF, a<b, signed-overflow formula; each done exactly 5 cycles apart.
- WIDTH=8, 1000 random pairs with random idle gaps -> scoreboard match; outputs stable between done pulses.
